// File: rtl/rv32im_pkg.sv
// Shared rv32im pipeline types: memory size codes, branch funct3 values,
// EX/MEM issue FSM states and the misalignment helper.
package rv32im_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN,
        ST_MWAIT
    } ex_mem_state_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        return ((size == SZ_HALF) && addr_lo[0])
            || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM to memory-access stage bundle with valid/ready handshake.
// misalign exists only when EX_MEM_MISALIGN_CHECK_EN is defined.
interface ex_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic            re;
    logic            we;
    logic [1:0]      size;
    logic [XLEN-1:0] store_data;
    logic            br_taken;
`ifdef EX_MEM_MISALIGN_CHECK_EN
    logic            misalign;
`endif

    modport master (
        output valid, result, rd_addr, rd_we, re, we,
        output size, store_data, br_taken,
`ifdef EX_MEM_MISALIGN_CHECK_EN
        output misalign,
`endif
        input  ready
    );

    modport slave (
        input  valid, result, rd_addr, rd_we, re, we,
        input  size, store_data, br_taken,
`ifdef EX_MEM_MISALIGN_CHECK_EN
        input  misalign,
`endif
        output ready
    );

endinterface

// File: rtl/branch_resolve.sv
// Conditional-branch decision from the ALU lsr/gtr/eql flags.
module branch_resolve
    import rv32im_pkg::*;
(
    input  logic       branch_i,
    input  logic [2:0] br_funct3_i,
    input  logic       lsr_i,
    input  logic       gtr_i,
    input  logic       eql_i,
    output logic       taken_o
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        unique case (br_funct3_i)
            F3_BEQ:           cond = eql_i;
            F3_BNE:           cond = !eql_i;
            F3_BLT, F3_BLTU:  cond = lsr_i;
            F3_BGE, F3_BGEU:  cond = gtr_i || eql_i;
            default:          cond = 1'b0;
        endcase
    end

    assign taken_o = branch_i && cond;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with M-extension settle window and branch resolve.
// Optional misaligned-access check: EX_MEM_MISALIGN_CHECK_EN.
module ex_mem_stage
    import rv32im_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MDU_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic            lsr_i,
    input  logic            gtr_i,
    input  logic            eql_i,
    input  logic            result_sel_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic [1:0]      mem_size_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            branch_i,
    input  logic [2:0]      br_funct3_i,
    ex_mem_stage_if.master  mem
);

    localparam bit         MDU_HOLD  = (MDU_CYCLES > 1);
    localparam logic [3:0] HOLD_INIT =
        MDU_HOLD ? 4'(MDU_CYCLES - 2) : 4'd0;

    ex_mem_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          space;
    logic          capture;
    logic          taken;
    logic          acc_re;
    logic          acc_we;

    assign space   = !mem.valid || mem.ready;
    assign capture = ex_valid_i && ex_ready_o && !flush_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_ready_o = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ex_valid_i && result_sel_i && MDU_HOLD) begin
                    state_d = ST_MWAIT;
                    cnt_d   = HOLD_INIT;
                end else begin
                    ex_ready_o = space;
                end
            end
            ST_MWAIT: begin
                ex_ready_o = (cnt_q == 4'd0) && space;
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                if (ex_valid_i && ex_ready_o)
                    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
        if (flush_i) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    branch_resolve u_br (
        .branch_i    (branch_i),
        .br_funct3_i (br_funct3_i),
        .lsr_i       (lsr_i),
        .gtr_i       (gtr_i),
        .eql_i       (eql_i),
        .taken_o     (taken)
    );

`ifdef EX_MEM_MISALIGN_CHECK_EN
    logic mis;

    assign mis    = (mem_re_i || mem_we_i)
                 && misaligned(mem_size_i, alu_out_i[1:0]);
    assign acc_re = mem_re_i && !mis;
    assign acc_we = mem_we_i && !mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem.misalign <= 1'b0;
        else if (flush_i)
            mem.misalign <= 1'b0;
        else if (capture)
            mem.misalign <= mis;
    end
`else
    assign acc_re = mem_re_i;
    assign acc_we = mem_we_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.valid      <= 1'b0;
            mem.result     <= '0;
            mem.rd_addr    <= '0;
            mem.rd_we      <= 1'b0;
            mem.re         <= 1'b0;
            mem.we         <= 1'b0;
            mem.size       <= '0;
            mem.store_data <= '0;
            mem.br_taken   <= 1'b0;
        end else if (flush_i) begin
            mem.valid    <= 1'b0;
            mem.rd_we    <= 1'b0;
            mem.re       <= 1'b0;
            mem.we       <= 1'b0;
            mem.br_taken <= 1'b0;
        end else if (capture) begin
            mem.valid      <= 1'b1;
            mem.result     <= alu_out_i;
            mem.rd_addr    <= rd_addr_i;
            mem.rd_we      <= rd_we_i;
            mem.re         <= acc_re;
            mem.we         <= acc_we;
            mem.size       <= mem_size_i;
            mem.store_data <= store_data_i;
            mem.br_taken   <= taken;
        end else begin
            // br_taken is a one-cycle pulse tied to the capture
            mem.br_taken <= 1'b0;
            if (mem.ready)
                mem.valid <= 1'b0;
        end
    end

endmodule
